// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Optional MULTU/DIVU support is enabled by defining MULTDIV_UNSIGNED_EN.
package mult_div_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic MD_MULT = 1'b0;
  localparam logic MD_DIV  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } md_state_t;

endpackage

// File: rtl/mult_div_unit_cond_negate.sv
// Conditional two's-complement negation, used for operand magnitudes
// and for the sign fix-up of results.
module cond_negate #(
  parameter int W = 32
) (
  input  logic         en,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  assign y = en ? (~x + W'(1)) : x;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed 32x32 multiply / 32/32 divide, one bit per cycle.
// Define MULTDIV_UNSIGNED_EN to add the unsigned_op port (MULTU/DIVU).
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             md_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULTDIV_UNSIGNED_EN
  input  logic             unsigned_op,
`endif
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH + 1);

  md_state_t          r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_md;
  logic               r_sa;
  logic               r_sb;
  logic               r_done;
  logic [WIDTH-1:0]   r_op;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signed;
  logic [WIDTH-1:0]   w_ma;
  logic [WIDTH-1:0]   w_mb;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH+1:0]   w_shift;
  logic [WIDTH+1:0]   w_diff;
  logic               w_neg;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

`ifdef MULTDIV_UNSIGNED_EN
  assign w_signed = ~unsigned_op;
`else
  assign w_signed = 1'b1;
`endif

  assign div0 = md_sel & (b == '0);
  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  cond_negate #(.W(WIDTH)) u_neg_a (
    .en (w_signed & a[WIDTH-1]),
    .x  (a),
    .y  (w_ma)
  );

  cond_negate #(.W(WIDTH)) u_neg_b (
    .en (w_signed & b[WIDTH-1]),
    .x  (b),
    .y  (w_mb)
  );

  // Multiply: r_op holds |a|, r_prod low half shifts out |b|.
  assign w_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
               + (r_prod[0] ? {1'b0, r_op} : '0);

  // Divide: r_op holds |b|, r_prod low half shifts |a| in / quotient out.
  assign w_shift = {r_rem, r_prod[WIDTH-1]};
  assign w_diff  = w_shift - {2'b00, r_op};

  assign w_neg = r_sa ^ r_sb;

  cond_negate #(.W(2*WIDTH)) u_neg_p (
    .en (w_neg),
    .x  (r_prod),
    .y  (w_prod_fix)
  );

  cond_negate #(.W(WIDTH)) u_neg_q (
    .en (w_neg),
    .x  (r_prod[WIDTH-1:0]),
    .y  (w_quo_fix)
  );

  cond_negate #(.W(WIDTH)) u_neg_r (
    .en (r_sa),
    .x  (r_rem[WIDTH-1:0]),
    .y  (w_rem_fix)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_md    <= MD_MULT;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_done  <= 1'b0;
      r_op    <= '0;
      r_prod  <= '0;
      r_rem   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start && !div0) begin
            r_state <= S_RUN;
            r_cnt   <= CW'(WIDTH);
            r_md    <= md_sel;
            r_sa    <= w_signed & a[WIDTH-1];
            r_sb    <= w_signed & b[WIDTH-1];
            r_op    <= (md_sel == MD_DIV) ? w_mb : w_ma;
            r_prod  <= {{WIDTH{1'b0}},
                        (md_sel == MD_DIV) ? w_ma : w_mb};
            r_rem   <= '0;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1))
            r_state <= S_FIX;
          if (r_md == MD_DIV) begin
            r_rem <= w_diff[WIDTH+1] ? w_shift[WIDTH:0]
                                     : w_diff[WIDTH:0];
            r_prod[WIDTH-1:0] <= {r_prod[WIDTH-2:0],
                                  ~w_diff[WIDTH+1]};
          end else begin
            r_prod <= {w_sum, r_prod[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          if (r_md == MD_DIV) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and random checks of mult_div_unit against a plain
// integer-arithmetic reference (64-bit products, truncating division).
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         md_sel;
  logic         unsigned_op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         div0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .md_sel      (md_sel),
    .a           (a),
    .b           (b),
`ifdef MULTDIV_UNSIGNED_EN
    .unsigned_op (unsigned_op),
`endif
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .done        (done),
    .div0        (div0)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference result packed as {hi, lo}.
  function automatic logic [63:0] model(input logic md,
                                        input logic [31:0] x,
                                        input logic [31:0] y,
                                        input logic uns);
    longint sx, sy, q, r;
    logic [63:0] res;
    if (uns) begin
      sx = longint'({32'h0, x});
      sy = longint'({32'h0, y});
    end else begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end
    if (!md) begin
      res = 64'(sx * sy);
    end else begin
      q = sx / sy;
      r = sx % sy;
      res = {r[31:0], q[31:0]};
    end
    return res;
  endfunction

  task automatic run_op(input string tag, input logic md,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic uns);
    logic [63:0] e;
    int n;
    e = model(md, x, y, uns);
    @(negedge clk);
    md_sel = md;
    a = x;
    b = y;
    unsigned_op = uns;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk({tag, "/busy"}, 64'(busy), 64'd1);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    chk({tag, "/lat"}, 64'(n), 64'(W + 1));
    chk({tag, "/hi"}, 64'(hi), 64'(e[63:32]));
    chk({tag, "/lo"}, 64'(lo), 64'(e[31:0]));
    @(posedge clk);
    #1;
    chk({tag, "/done_fall"}, 64'(done), 64'd0);
    chk({tag, "/idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [31:0] ph;
    logic [31:0] pl;
    logic [31:0] rx;
    logic [31:0] ry;
    logic        rm;
    int          nd;

    reset = 1'b1;
    start = 1'b0;
    md_sel = 1'b0;
    unsigned_op = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst/hi", 64'(hi), 64'd0);
    chk("rst/lo", 64'(lo), 64'd0);
    chk("rst/busy", 64'(busy), 64'd0);
    chk("rst/done", 64'(done), 64'd0);
    chk("rst/div0", 64'(div0), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("mul7xm3", 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0);
    chk("mul7xm3/hi_const", 64'(hi), 64'hFFFF_FFFF);
    chk("mul7xm3/lo_const", 64'(lo), 64'hFFFF_FFEB);
    run_op("mulmin", 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    chk("mulmin/hi_const", 64'(hi), 64'h4000_0000);
    run_op("divm7", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("divm7/lo_const", 64'(lo), 64'hFFFF_FFFD);
    chk("divm7/hi_const", 64'(hi), 64'hFFFF_FFFF);
    run_op("divovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("divovf/lo_const", 64'(lo), 64'h8000_0000);
    run_op("div_sgn", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);

    // Divide by zero: flagged at once, ignored by the FSM.
    run_op("pre_div0", 1'b0, 32'd1234, 32'd5678, 1'b0);
    ph = hi;
    pl = lo;
    @(negedge clk);
    md_sel = 1'b1;
    a = 32'd99;
    b = 32'd0;
    start = 1'b1;
    #1;
    chk("div0/flag", 64'(div0), 64'd1);
    @(posedge clk);
    #1 start = 1'b0;
    chk("div0/busy", 64'(busy), 64'd0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 if (done) nd++;
    end
    chk("div0/no_done", 64'(nd), 64'd0);
    chk("div0/hi_hold", 64'(hi), 64'(ph));
    chk("div0/lo_hold", 64'(lo), 64'(pl));
    md_sel = 1'b0;
    #1;
    chk("div0/mul_sel", 64'(div0), 64'd0);

    // Reset 10 cycles into a multiply.
    @(negedge clk);
    md_sel = 1'b0;
    a = 32'h1234_5678;
    b = 32'h9ABC_DEF0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort/busy", 64'(busy), 64'd0);
    chk("abort/hi", 64'(hi), 64'd0);
    chk("abort/lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 if (done) nd++;
    end
    chk("abort/no_done", 64'(nd), 64'd0);
    run_op("mul3x5", 1'b0, 32'd3, 32'd5, 1'b0);
    chk("mul3x5/lo_const", 64'(lo), 64'd15);

`ifdef MULTDIV_UNSIGNED_EN
    run_op("divu", 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b1);
    chk("divu/lo_const", 64'(lo), 64'h7FFF_FFFF);
    run_op("multu", 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b1);
    chk("multu/hi_const", 64'(hi), 64'd1);
`endif

    for (int k = 0; k < 24; k++) begin
      rm = 1'($urandom_range(0, 1));
      rx = $urandom;
      ry = $urandom;
      if (k % 4 == 0) ry = ry >> $urandom_range(8, 28);
      if (k % 5 == 0) rx = {rx[31], 31'h0};
      if (rm && ry == 0) ry = 32'd3;
`ifdef MULTDIV_UNSIGNED_EN
      run_op("rand", rm, rx, ry, 1'($urandom_range(0, 1)));
`else
      run_op("rand", rm, rx, ry, 1'b0);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
